// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory access path.
//   - DMType access codes (also used by the main control decoder)
//   - FSM state encoding for dm_access_unit
//   - captured request struct
//   - legality, byte-enable and store-lane helper functions
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dm_state_e;

    // Only the fields the access/response phases need; the word index is
    // kept separately because its width follows ADDR_WIDTH.
    typedef struct packed {
        logic        mem_w;
        logic [2:0]  dm_type;
        logic [1:0]  byte_off;
        logic [31:0] wdata;
    } dm_req_t;

    // Misaligned accesses, unknown codes and stores using the load-only
    // unsigned codes are rejected before touching memory.
    function automatic logic dm_illegal(input logic mem_w, input logic [2:0] t,
                                        input logic [1:0] off);
        logic bad;
        bad = 1'b1;
        case (t)
            DM_WORD:   bad = (off != 2'b00);
            DM_HALF:   bad = off[0];
            DM_HALF_U: bad = mem_w | off[0];
            DM_BYTE:   bad = 1'b0;
            DM_BYTE_U: bad = mem_w;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] dm_byte_en(input logic [2:0] t, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (t)
            DM_WORD:              be = 4'b1111;
            DM_HALF, DM_HALF_U:   be = off[1] ? 4'b1100 : 4'b0011;
            DM_BYTE, DM_BYTE_U:   be = 4'b0001 << off;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the right-aligned store data onto every lane it could land
    // in; the byte enables pick the lane that is actually written.
    function automatic logic [31:0] dm_store_lanes(input logic [2:0] t, input logic [31:0] d);
        logic [31:0] lanes;
        lanes = d;
        case (t)
            DM_HALF, DM_HALF_U: lanes = {2{d[15:0]}};
            DM_BYTE, DM_BYTE_U: lanes = {4{d[7:0]}};
            default:            lanes = d;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// dm_ram: 2^ADDR_WIDTH x 32 synchronous RAM, four byte write enables,
// read enable and a registered read port.
// Ports:
//   clk, rst  - clock; async active-high reset clears q only (array kept)
//   we[3:0]   - per-byte write enables
//   re        - read enable; q loads mem[addr] on the edge
//   addr      - word index
//   wdata     - lane-aligned write data
//   q         - registered read data, holds its value while re is low
module dm_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] rd_word;

    generate
        if (INIT_ZERO) begin : g_mem_zero
            logic [31:0] mem [DEPTH] = '{default: '0};

            always_ff @(posedge clk) begin
                for (int b = 0; b < 4; b++) begin
                    if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end

            assign rd_word = mem[addr];
        end else begin : g_mem_raw
            logic [31:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                for (int b = 0; b < 4; b++) begin
                    if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end

            assign rd_word = mem[addr];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (re) q <= rd_word;
    end

endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: data-memory responder for the single-cycle core.
// Accepts one load/store at a time, performs byte/half/word accesses on
// dm_ram, and returns extended load data or an error response.
// Ports:
//   clk, rst              - clock, async active-high reset
//   req_valid / req_ready - request handshake (ready only in IDLE)
//   mem_w                 - 1 store, 0 load
//   dm_type               - access code (see dm_pkg)
//   addr, wdata           - byte address, right-aligned store data
//   rsp_valid / rsp_ready - response handshake
//   rdata                 - extended load data; 0 for stores and errors
//   err                   - misaligned/illegal request, memory untouched
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_w,
    input  logic [2:0]  dm_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rdata,
    output logic        err
);

    dm_state_e             state_q, state_d;
    dm_req_t               req_q;
    logic [ADDR_WIDTH-1:0] widx_q;
    logic                  err_q;

    logic                  accept;
    logic                  illegal;
    logic                  in_access;
    logic [3:0]            ram_we;
    logic                  ram_re;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_q;
    logic [31:0]           load_fmt;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;

    // Upper address bits do not select anything: the space wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    assign accept  = (state_q == ST_IDLE) && req_valid;
    assign illegal = dm_illegal(mem_w, dm_type, addr[1:0]);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = illegal ? ST_RESP : ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- request capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q  <= '0;
            widx_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            req_q  <= '{mem_w: mem_w, dm_type: dm_type, byte_off: addr[1:0], wdata: wdata};
            widx_q <= addr[ADDR_WIDTH+1:2];
            err_q  <= illegal;
        end
    end

    // ---------------- RAM control ----------------
    // Enables derive from the registered state, so a reset that lands
    // before the ACCESS edge suppresses the write entirely.
    assign in_access = (state_q == ST_ACCESS);
    assign ram_we    = (in_access && req_q.mem_w) ? dm_byte_en(req_q.dm_type, req_q.byte_off) : 4'b0000;
    assign ram_re    = in_access && !req_q.mem_w;
    assign ram_wdata = dm_store_lanes(req_q.dm_type, req_q.wdata);

    dm_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_ZERO  (INIT_ZERO)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (widx_q),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // ---------------- load formatting ----------------
    // ram_q only moves on a read enable, so this stays stable in RESP.
    always_comb begin
        lane_b = ram_q[7:0];
        case (req_q.byte_off)
            2'd0: lane_b = ram_q[7:0];
            2'd1: lane_b = ram_q[15:8];
            2'd2: lane_b = ram_q[23:16];
            2'd3: lane_b = ram_q[31:24];
            default: lane_b = ram_q[7:0];
        endcase
        lane_h = req_q.byte_off[1] ? ram_q[31:16] : ram_q[15:0];

        load_fmt = '0;
        case (req_q.dm_type)
            DM_WORD:   load_fmt = ram_q;
            DM_HALF:   load_fmt = {{16{lane_h[15]}}, lane_h};
            DM_HALF_U: load_fmt = {16'h0000, lane_h};
            DM_BYTE:   load_fmt = {{24{lane_b[7]}}, lane_b};
            DM_BYTE_U: load_fmt = {24'h000000, lane_b};
            default:   load_fmt = '0;
        endcase
    end

    // ---------------- outputs ----------------
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign err       = rsp_valid && err_q;
    assign rdata     = (rsp_valid && !err_q && !req_q.mem_w) ? load_fmt : 32'h0;

endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;
    import dm_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        mem_w;
    logic [2:0]  dm_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        err;

    int tests;
    int fails;
    int cyc;

    dm_access_unit #(.ADDR_WIDTH(10), .INIT_ZERO(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_w     (mem_w),
        .dm_type   (dm_type),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rdata     (rdata),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Issue one request with rsp_ready high; lat counts edges from accept
    // (inclusive) until rsp_valid is seen, bounded at 10.
    task automatic do_req(input logic w, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic e,
                          output int lat, output int ac);
        @(negedge clk);
        mem_w = w; dm_type = t; addr = a; wdata = d; req_valid = 1'b1;
        @(posedge clk); #1;
        ac = cyc;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata;
        e  = err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic e; int lat, ac; logic seen;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", err); end
        @(negedge clk); rst = 1'b0;

        do_req(1'b1, DM_WORD, 32'h40, 32'hCAFEF00D, rd, e, lat, ac);
        // load held in RESP, then reset
        rsp_ready = 1'b0;
        @(negedge clk);
        mem_w = 1'b0; dm_type = DM_WORD; addr = 32'h40; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL midload_rdata got %h want cafef00d", rdata); end
        #2 rst = 1'b1; #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_rsp_valid got %0b want 0", rsp_valid); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_req_ready got %0b want 1", req_ready); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rst_mid_rdata got %h want 0", rdata); end
        @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_no_rsp got %0b want 0", seen); end

        // store captured, reset before its ACCESS edge: never written
        @(negedge clk);
        mem_w = 1'b1; dm_type = DM_WORD; addr = 32'h40; wdata = 32'h11111111; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        do_req(1'b0, DM_WORD, 32'h40, 32'h0, rd, e, lat, ac);
        tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL rst_store_dropped got %h want cafef00d", rd); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int lat, ac;
        do_req(1'b1, DM_WORD, 32'h10, 32'hDEADBEEF, rd, e, lat, ac);
        tests++; if (lat !== 2) begin fails++; $display("FAIL word_store_lat got %0d want 2", lat); end
        tests++; if (rd !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL word_store_rsp got %h/%0b want 0/0", rd, e); end
        do_req(1'b0, DM_WORD, 32'h10, 32'h0, rd, e, lat, ac);
        tests++; if (lat !== 2) begin fails++; $display("FAIL word_load_lat got %0d want 2", lat); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL word_load_data got %h want deadbeef", rd); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL word_load_err got %0b want 0", e); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic e; int lat, ac;
        do_req(1'b1, DM_BYTE, 32'h12, 32'hAAAAAA7F, rd, e, lat, ac);
        do_req(1'b0, DM_WORD, 32'h10, 32'h0, rd, e, lat, ac);
        tests++; if (rd !== 32'hDE7FBEEF) begin fails++; $display("FAIL byte_word_merge got %h want de7fbeef", rd); end
        do_req(1'b0, DM_BYTE, 32'h13, 32'h0, rd, e, lat, ac);
        tests++; if (rd !== 32'hFFFFFFDE) begin fails++; $display("FAIL byte_sext got %h want ffffffde", rd); end
        do_req(1'b0, DM_BYTE_U, 32'h13, 32'h0, rd, e, lat, ac);
        tests++; if (rd !== 32'h000000DE) begin fails++; $display("FAIL byte_zext got %h want 000000de", rd); end
        do_req(1'b0, DM_BYTE, 32'h12, 32'h0, rd, e, lat, ac);
        tests++; if (rd !== 32'h0000007F) begin fails++; $display("FAIL byte_pos got %h want 0000007f", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic e; int lat, ac;
        do_req(1'b1, DM_HALF, 32'h22, 32'h12348001, rd, e, lat, ac);
        do_req(1'b0, DM_HALF, 32'h22, 32'h0, rd, e, lat, ac);
        tests++; if (rd !== 32'hFFFF8001) begin fails++; $display("FAIL half_sext got %h want ffff8001", rd); end
        do_req(1'b0, DM_HALF_U, 32'h22, 32'h0, rd, e, lat, ac);
        tests++; if (rd !== 32'h00008001) begin fails++; $display("FAIL half_zext got %h want 00008001", rd); end
        do_req(1'b0, DM_WORD, 32'h20, 32'h0, rd, e, lat, ac);
        tests++; if (rd !== 32'h80010000) begin fails++; $display("FAIL half_word_view got %h want 80010000", rd); end
    endtask

    task automatic test_errors();
        logic        ew [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  et [5] = '{DM_WORD, DM_HALF, DM_BYTE_U, 3'b110, DM_WORD};
        logic [31:0] ea [5] = '{32'h11, 32'h13, 32'h10, 32'h10, 32'h11};
        logic [31:0] rd; logic e; int lat, ac;
        for (int i = 0; i < 5; i++) begin
            do_req(ew[i], et[i], ea[i], 32'h55555555, rd, e, lat, ac);
            tests++; if (e !== 1'b1) begin fails++; $display("FAIL err%0d_flag got %0b want 1", i, e); end
            tests++; if (rd !== 32'h0) begin fails++; $display("FAIL err%0d_rdata got %h want 0", i, rd); end
            tests++; if (lat !== 1) begin fails++; $display("FAIL err%0d_lat got %0d want 1", i, lat); end
            do_req(1'b0, DM_WORD, 32'h10, 32'h0, rd, e, lat, ac);
            tests++; if (rd !== 32'hDE7FBEEF) begin fails++; $display("FAIL err%0d_mem got %h want de7fbeef", i, rd); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic e; int lat, ac;
        rsp_ready = 1'b0;
        @(negedge clk);
        mem_w = 1'b0; dm_type = DM_WORD; addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_access_ready got %0b want 0", req_ready); end
        @(posedge clk); #1;
        // a competing store must be ignored while busy
        mem_w = 1'b1; dm_type = DM_WORD; addr = 32'h10; wdata = 32'h0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp%0d_valid got %0b want 1", i, rsp_valid); end
            tests++; if (rdata !== 32'hDE7FBEEF) begin fails++; $display("FAIL bp%0d_rdata got %h want de7fbeef", i, rdata); end
            tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp%0d_ready got %0b want 0", i, req_ready); end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL bp_release got %0b/%0b want 0/1", rsp_valid, req_ready); end
        do_req(1'b0, DM_WORD, 32'h10, 32'h0, rd, e, lat, ac);
        tests++; if (rd !== 32'hDE7FBEEF) begin fails++; $display("FAIL bp_ignored_store got %h want de7fbeef", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic e; int lat, ac;
        do_req(1'b1, DM_WORD, 32'h1000, 32'h0BADF00D, rd, e, lat, ac);
        do_req(1'b0, DM_WORD, 32'h0, 32'h0, rd, e, lat, ac);
        tests++; if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL wrap_low got %h want 0badf00d", rd); end
        do_req(1'b0, DM_WORD, 32'hFFFFF000, 32'h0, rd, e, lat, ac);
        tests++; if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL wrap_high got %h want 0badf00d", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int lat, ac1, ac2;
        do_req(1'b1, DM_WORD, 32'h30, 32'h13579BDF, rd, e, lat, ac1);
        do_req(1'b0, DM_WORD, 32'h30, 32'h0, rd, e, lat, ac2);
        tests++; if (ac2 - ac1 !== 3) begin fails++; $display("FAIL b2b_spacing got %0d want 3", ac2 - ac1); end
        tests++; if (rd !== 32'h13579BDF) begin fails++; $display("FAIL b2b_data got %h want 13579bdf", rd); end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        rst = 1'b1; req_valid = 1'b0; mem_w = 1'b0; dm_type = DM_WORD;
        addr = 32'h0; wdata = 32'h0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
